// File: rtl/lr_pkg.sv
// Shared definitions for the local-management packet arbiter: word layout,
// flag encodings, FSM states and saturating counter helpers.
package lr_pkg;

    localparam int WORD_W = 134;

    localparam logic [1:0] FLAG_HEAD = 2'b01;
    localparam logic [1:0] FLAG_MID  = 2'b11;
    localparam logic [1:0] FLAG_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } lr_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {14'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] a);
        return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
    endfunction

endpackage

// File: rtl/lr_rr_arb2.sv
// Two-requester selector: round-robin pointer or fixed priority to B,
// chosen by PRIO_MODE. The pointer moves only when a packet completes.
module lr_rr_arb2 #(
    parameter int PRIO_MODE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_upd,
    input  logic i_upd_b,
    output logic o_pick_a,
    output logic o_pick_b
);

    logic r_prefer_b;

    // After serving a source, the other one wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prefer_b <= 1'b0;
        end else if (i_upd) begin
            r_prefer_b <= ~i_upd_b;
        end
    end

    always_comb begin
        o_pick_a = 1'b0;
        o_pick_b = 1'b0;
        if (i_req_a && i_req_b) begin
            if (PRIO_MODE == 1 || r_prefer_b) begin
                o_pick_b = 1'b1;
            end else begin
                o_pick_a = 1'b1;
            end
        end else begin
            o_pick_a = i_req_a;
            o_pick_b = i_req_b;
        end
    end

endmodule

// File: rtl/lr_pkt_arbiter.sv
// Packet-granular 2:1 arbiter onto the registered lupdate datapath.
// Optional head-to-tail watchdog with forced abort: define LRA_WDOG_EN.
module lr_pkt_arbiter import lr_pkg::*; #(
    parameter int PRIO_MODE    = 0,
    parameter int GNT_WAIT_MAX = 16
`ifdef LRA_WDOG_EN
    , parameter int WDOG_CYCLES = 256
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_a_req,
    output logic              out_a_grant,
    input  logic              in_a_data_wr,
    input  logic [WORD_W-1:0] in_a_data,
    input  logic              in_a_data_valid,
    input  logic              in_a_data_valid_wr,
    input  logic              in_b_req,
    output logic              out_b_grant,
    input  logic              in_b_data_wr,
    input  logic [WORD_W-1:0] in_b_data,
    input  logic              in_b_data_valid,
    input  logic              in_b_data_valid_wr,
    output logic              out_data_wr,
    output logic [WORD_W-1:0] out_data,
    output logic              out_data_valid,
    output logic              out_data_valid_wr,
    output logic              out_busy,
    output logic [31:0]       out_a_pkt_cnt,
    output logic [31:0]       out_b_pkt_cnt,
    output logic [15:0]       out_err_cnt
`ifdef LRA_WDOG_EN
    , output logic [15:0]     out_wdog_cnt
`endif
);

    localparam int WAIT_W = (GNT_WAIT_MAX > 2) ? $clog2(GNT_WAIT_MAX) : 1;

    lr_state_t         r_state;
    logic              r_gnt_a;
    logic              r_gnt_b;
    logic [WAIT_W-1:0] r_wait;
    logic              r_out_wr;
    logic [WORD_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_valid_wr;
    logic [31:0]       r_a_pkt_cnt;
    logic [31:0]       r_b_pkt_cnt;
    logic [15:0]       r_err_cnt;

    logic              w_pick_a;
    logic              w_pick_b;
    logic              w_g_wr;
    logic [WORD_W-1:0] w_g_data;
    logic              w_g_valid;
    logic              w_g_valid_wr;
    logic [1:0]        w_g_flag;
    logic              w_g_head;
    logic              w_g_tail;
    logic              w_wait_done;
    logic              w_abort;
    logic              w_upd;
    logic [2:0]        w_err_inc;

    // The grant registers double as the source select for the data mux.
    assign w_g_wr       = (r_gnt_a & in_a_data_wr) | (r_gnt_b & in_b_data_wr);
    assign w_g_data     = r_gnt_b ? in_b_data          : in_a_data;
    assign w_g_valid    = r_gnt_b ? in_b_data_valid    : in_a_data_valid;
    assign w_g_valid_wr = r_gnt_b ? in_b_data_valid_wr : in_a_data_valid_wr;
    assign w_g_flag     = w_g_data[WORD_W-1 -: 2];
    assign w_g_head     = w_g_wr && (w_g_flag == FLAG_HEAD);
    assign w_g_tail     = w_g_wr && (w_g_flag == FLAG_TAIL);
    assign w_wait_done  = (r_wait == WAIT_W'(GNT_WAIT_MAX - 1));
    assign w_upd        = (r_state == ST_XFER) && (w_g_tail || w_abort);

    // Per-cycle error events: stray words from the ungranted side, non-head
    // words while waiting, grant timeout, and a second head inside a packet.
    assign w_err_inc = 3'(in_a_data_wr & ~r_gnt_a)
                     + 3'(in_b_data_wr & ~r_gnt_b)
                     + 3'((r_state == ST_GRANT) && w_g_wr && !w_g_head)
                     + 3'((r_state == ST_GRANT) && !w_g_head && w_wait_done)
                     + 3'((r_state == ST_XFER) && w_g_head);

    lr_rr_arb2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req_a  (in_a_req),
        .i_req_b  (in_b_req),
        .i_upd    (w_upd),
        .i_upd_b  (r_gnt_b),
        .o_pick_a (w_pick_a),
        .o_pick_b (w_pick_b)
    );

`ifdef LRA_WDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

    logic [WDOG_W-1:0] r_wdog;
    logic [15:0]       r_wdog_cnt;

    // A real tail in the limit cycle wins over the forced abort.
    assign w_abort = (r_state == ST_XFER) && !w_g_tail &&
                     (r_wdog == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog     <= '0;
            r_wdog_cnt <= '0;
        end else begin
            if (r_state == ST_GRANT && w_g_head) begin
                r_wdog <= WDOG_W'(1);
            end else if (r_state == ST_XFER) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_abort) begin
                r_wdog_cnt <= sat_add16(r_wdog_cnt, 3'd1);
            end
        end
    end

    assign out_wdog_cnt = r_wdog_cnt;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_gnt_a        <= 1'b0;
            r_gnt_b        <= 1'b0;
            r_wait         <= '0;
            r_out_wr       <= 1'b0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_out_valid_wr <= 1'b0;
            r_a_pkt_cnt    <= '0;
            r_b_pkt_cnt    <= '0;
            r_err_cnt      <= '0;
        end else begin
            r_out_wr       <= 1'b0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_out_valid_wr <= 1'b0;
            r_err_cnt      <= sat_add16(r_err_cnt, w_err_inc);
            case (r_state)
                ST_IDLE: begin
                    r_wait <= '0;
                    if (w_pick_a || w_pick_b) begin
                        r_gnt_a <= w_pick_a;
                        r_gnt_b <= w_pick_b;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_g_head) begin
                        r_out_wr       <= 1'b1;
                        r_out_data     <= w_g_data;
                        r_out_valid    <= w_g_valid;
                        r_out_valid_wr <= w_g_valid_wr;
                        r_state        <= ST_XFER;
                    end else if (w_wait_done) begin
                        r_gnt_a <= 1'b0;
                        r_gnt_b <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (w_g_tail) begin
                        r_out_wr       <= 1'b1;
                        r_out_data     <= w_g_data;
                        r_out_valid    <= w_g_valid;
                        r_out_valid_wr <= w_g_valid_wr;
                        if (r_gnt_b) begin
                            r_b_pkt_cnt <= sat_inc32(r_b_pkt_cnt);
                        end else begin
                            r_a_pkt_cnt <= sat_inc32(r_a_pkt_cnt);
                        end
                        r_gnt_a <= 1'b0;
                        r_gnt_b <= 1'b0;
                        r_state <= ST_GAP;
                    end else if (w_abort) begin
                        // Synthetic tail flagged invalid so downstream drops the packet.
                        r_out_wr       <= 1'b1;
                        r_out_data     <= {FLAG_TAIL, {(WORD_W-2){1'b0}}};
                        r_out_valid_wr <= 1'b1;
                        r_gnt_a        <= 1'b0;
                        r_gnt_b        <= 1'b0;
                        r_state        <= ST_GAP;
                    end else if (w_g_wr) begin
                        r_out_wr       <= 1'b1;
                        r_out_data     <= w_g_data;
                        r_out_valid    <= w_g_valid;
                        r_out_valid_wr <= w_g_valid_wr;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_a_grant       = r_gnt_a;
    assign out_b_grant       = r_gnt_b;
    assign out_data_wr       = r_out_wr;
    assign out_data          = r_out_data;
    assign out_data_valid    = r_out_valid;
    assign out_data_valid_wr = r_out_valid_wr;
    assign out_busy          = (r_state != ST_IDLE);
    assign out_a_pkt_cnt     = r_a_pkt_cnt;
    assign out_b_pkt_cnt     = r_b_pkt_cnt;
    assign out_err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_lr_pkt_arbiter.sv
// Directed bench for lr_pkt_arbiter: instance 0 is round-robin, instance 1 is
// fixed priority to B. Build with LRA_WDOG_EN to include the watchdog case.
module tb_lr_pkt_arbiter;
    import lr_pkg::*;

`ifdef LRA_WDOG_EN
    localparam int LEN2 = 8;
`else
    localparam int LEN2 = 13;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              a_req[2], a_wr[2], a_v[2], a_vwr[2];
    logic              b_req[2], b_wr[2], b_v[2], b_vwr[2];
    logic [WORD_W-1:0] a_data[2], b_data[2];
    logic              a_gnt[2], b_gnt[2], o_wr[2], o_v[2], o_vwr[2], busy[2];
    logic [WORD_W-1:0] o_data[2];
    logic [31:0]       a_cnt[2], b_cnt[2];
    logic [15:0]       err_cnt[2];
`ifdef LRA_WDOG_EN
    logic [15:0]       wdog_cnt[2];
`endif

    logic [135:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail = 0;
    logic         mon_en = 1'b0;
    logic [31:0]  seq = 32'd0;

    lr_pkt_arbiter #(
        .PRIO_MODE(0), .GNT_WAIT_MAX(16)
`ifdef LRA_WDOG_EN
        , .WDOG_CYCLES(8)
`endif
    ) u_rr (
        .clk(clk), .rst_n(rst_n),
        .in_a_req(a_req[0]), .out_a_grant(a_gnt[0]), .in_a_data_wr(a_wr[0]),
        .in_a_data(a_data[0]), .in_a_data_valid(a_v[0]), .in_a_data_valid_wr(a_vwr[0]),
        .in_b_req(b_req[0]), .out_b_grant(b_gnt[0]), .in_b_data_wr(b_wr[0]),
        .in_b_data(b_data[0]), .in_b_data_valid(b_v[0]), .in_b_data_valid_wr(b_vwr[0]),
        .out_data_wr(o_wr[0]), .out_data(o_data[0]), .out_data_valid(o_v[0]),
        .out_data_valid_wr(o_vwr[0]), .out_busy(busy[0]), .out_a_pkt_cnt(a_cnt[0]),
        .out_b_pkt_cnt(b_cnt[0]), .out_err_cnt(err_cnt[0])
`ifdef LRA_WDOG_EN
        , .out_wdog_cnt(wdog_cnt[0])
`endif
    );

    lr_pkt_arbiter #(
        .PRIO_MODE(1), .GNT_WAIT_MAX(16)
`ifdef LRA_WDOG_EN
        , .WDOG_CYCLES(8)
`endif
    ) u_fp (
        .clk(clk), .rst_n(rst_n),
        .in_a_req(a_req[1]), .out_a_grant(a_gnt[1]), .in_a_data_wr(a_wr[1]),
        .in_a_data(a_data[1]), .in_a_data_valid(a_v[1]), .in_a_data_valid_wr(a_vwr[1]),
        .in_b_req(b_req[1]), .out_b_grant(b_gnt[1]), .in_b_data_wr(b_wr[1]),
        .in_b_data(b_data[1]), .in_b_data_valid(b_v[1]), .in_b_data_valid_wr(b_vwr[1]),
        .out_data_wr(o_wr[1]), .out_data(o_data[1]), .out_data_valid(o_v[1]),
        .out_data_valid_wr(o_vwr[1]), .out_busy(busy[1]), .out_a_pkt_cnt(a_cnt[1]),
        .out_b_pkt_cnt(b_cnt[1]), .out_err_cnt(err_cnt[1])
`ifdef LRA_WDOG_EN
        , .out_wdog_cnt(wdog_cnt[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard on instance 0: every output word must match the queue head,
    // and idle cycles must present an all-zero output.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_wr[0]) begin
                if (exp_q.size() == 0) check_eq("extra_word", 136'(o_wr[0]), 136'd0);
                else check_eq("out_word", {o_v[0], o_vwr[0], o_data[0]}, exp_q.pop_front());
            end else begin
                check_eq("idle_out", {o_v[0], o_vwr[0], o_data[0]}, 136'd0);
            end
        end
    end

    task automatic do_reset();
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            a_req[d] = 0; a_wr[d] = 0; a_v[d] = 0; a_vwr[d] = 0; a_data[d] = '0;
            b_req[d] = 0; b_wr[d] = 0; b_v[d] = 0; b_vwr[d] = 0; b_data[d] = '0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    // One word from one source for one cycle; noise makes the other source
    // write a junk head in the same cycle.
    task automatic drive_word(input int d, input bit src_b, input logic [1:0] fl,
                              input bit noise, input bit fwd);
        logic t;
        logic [WORD_W-1:0] w;
        t   = (fl == FLAG_TAIL);
        seq = seq + 32'd1;
        w   = {fl, (src_b ? 4'hB : 4'hA), 96'h0, seq};
        if (src_b) begin
            b_wr[d] = 1; b_data[d] = w; b_v[d] = t; b_vwr[d] = t;
            a_wr[d] = noise; a_data[d] = {FLAG_HEAD, 4'hE, 96'h0, seq};
        end else begin
            a_wr[d] = 1; a_data[d] = w; a_v[d] = t; a_vwr[d] = t;
            b_wr[d] = noise; b_data[d] = {FLAG_HEAD, 4'hE, 96'h0, seq};
        end
        if (d == 0 && fwd) exp_q.push_back({t, t, w});
        tick();
        a_wr[d] = 0; a_v[d] = 0; a_vwr[d] = 0;
        b_wr[d] = 0; b_v[d] = 0; b_vwr[d] = 0;
    endtask

    task automatic send_pkt(input int d, input bit src_b, input int len,
                            input bit noise, input bit dup_head);
        logic [1:0] fl;
        for (int i = 0; i < len; i++) begin
            if (i == 0 || (dup_head && i == 1)) fl = FLAG_HEAD;
            else if (i == len - 1)              fl = FLAG_TAIL;
            else                                fl = FLAG_MID;
            drive_word(d, src_b, fl, noise && i > 0 && i < len - 1, 1'b1);
        end
    endtask

    task automatic wait_grant(input int d, input bit exp_b);
        int n = 0;
        while (!(a_gnt[d] || b_gnt[d]) && n < 40) begin
            tick();
            n++;
        end
        check_eq(exp_b ? "grant_b" : "grant_a", {134'd0, a_gnt[d], b_gnt[d]},
                 exp_b ? 136'd1 : 136'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        do_reset();

        // Reset state
        check_eq("rst_grants", {134'd0, a_gnt[0], b_gnt[0]}, 136'd0);
        check_eq("rst_busy", 136'(busy[0]), 136'd0);
        check_eq("rst_a_cnt", 136'(a_cnt[0]), 136'd0);
        check_eq("rst_b_cnt", 136'(b_cnt[0]), 136'd0);
        check_eq("rst_err", 136'(err_cnt[0]), 136'd0);
        check_eq("rst_grants_fp", {134'd0, a_gnt[1], b_gnt[1]}, 136'd0);

        // A alone, 3-word packet, one bubble afterwards
        a_req[0] = 1;
        wait_grant(0, 0);
        a_req[0] = 0;
        check_eq("t1_busy_grant", 136'(busy[0]), 136'd1);
        send_pkt(0, 0, 3, 0, 0);
        check_eq("t1_gnt_drop", 136'(a_gnt[0]), 136'd0);
        check_eq("t1_a_cnt", 136'(a_cnt[0]), 136'd1);
        check_eq("t1_busy_gap", 136'(busy[0]), 136'd1);
        tick();
        check_eq("t1_bubble", 136'(o_wr[0]), 136'd0);
        check_eq("t1_busy_idle", 136'(busy[0]), 136'd0);
        check_eq("t1_err", 136'(err_cnt[0]), 136'd0);

        // Round-robin with both requesting continuously
        do_reset();
        a_req[0] = 1;
        b_req[0] = 1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(0, k % 2 == 1);
            if (k == 3) begin
                a_req[0] = 0;
                b_req[0] = 0;
            end
            send_pkt(0, k % 2 == 1, LEN2, 0, 0);
        end
        tick();
        check_eq("t2_a_cnt", 136'(a_cnt[0]), 136'd2);
        check_eq("t2_b_cnt", 136'(b_cnt[0]), 136'd2);
        check_eq("t2_err", 136'(err_cnt[0]), 136'd0);

        // Fixed priority: B wins every tie, A only after B drops its request
        do_reset();
        a_req[1] = 1;
        b_req[1] = 1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(1, 1);
            if (k == 3) b_req[1] = 0;
            send_pkt(1, 1, 2, 0, 0);
        end
        wait_grant(1, 0);
        a_req[1] = 0;
        send_pkt(1, 0, 2, 0, 0);
        check_eq("t3_b_cnt", 136'(b_cnt[1]), 136'd4);
        check_eq("t3_a_cnt", 136'(a_cnt[1]), 136'd1);
        check_eq("t3_err", 136'(err_cnt[1]), 136'd0);

        // Grant with no head: withdrawn after 16 cycles
        do_reset();
        a_req[0] = 1;
        wait_grant(0, 0);
        a_req[0] = 0;
        n = 0;
        while (a_gnt[0] && n < 40) begin
            n++;
            tick();
        end
        check_eq("t4_gnt_cycles", 136'(n), 136'd16);
        check_eq("t4_err", 136'(err_cnt[0]), 136'd1);
        check_eq("t4_busy", 136'(busy[0]), 136'd0);
        check_eq("t4_a_cnt", 136'(a_cnt[0]), 136'd0);

        // Stray mid before head, duplicate head, B noise during A's packet
        do_reset();
        a_req[0] = 1;
        wait_grant(0, 0);
        a_req[0] = 0;
        drive_word(0, 0, FLAG_MID, 0, 0);
        send_pkt(0, 0, 5, 1, 1);
        check_eq("t5_err", 136'(err_cnt[0]), 136'd5);
        check_eq("t5_a_cnt", 136'(a_cnt[0]), 136'd1);
        check_eq("t5_b_cnt", 136'(b_cnt[0]), 136'd0);

        // Asynchronous reset in the middle of a packet
        do_reset();
        a_req[0] = 1;
        wait_grant(0, 0);
        a_req[0] = 0;
        drive_word(0, 0, FLAG_HEAD, 0, 1);
        drive_word(0, 0, FLAG_MID, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_gnt", 136'(a_gnt[0]), 136'd0);
        check_eq("t6_rst_wr", 136'(o_wr[0]), 136'd0);
        check_eq("t6_rst_busy", 136'(busy[0]), 136'd0);

`ifdef LRA_WDOG_EN
        // Head only: synthetic invalid tail 8 cycles after the head
        do_reset();
        a_req[0] = 1;
        wait_grant(0, 0);
        a_req[0] = 0;
        drive_word(0, 0, FLAG_HEAD, 0, 1);
        exp_q.push_back({1'b0, 1'b1, FLAG_TAIL, 132'h0});
        for (int i = 0; i < 6; i++) tick();
        check_eq("t7_no_early_tail", 136'(o_wr[0]), 136'd0);
        tick();
        check_eq("t7_tail_wr", 136'(o_wr[0]), 136'd1);
        check_eq("t7_wdog_cnt", 136'(wdog_cnt[0]), 136'd1);
        check_eq("t7_gnt_drop", 136'(a_gnt[0]), 136'd0);
        check_eq("t7_busy_gap", 136'(busy[0]), 136'd1);
        check_eq("t7_a_cnt", 136'(a_cnt[0]), 136'd0);
        tick();
        check_eq("t7_busy_idle", 136'(busy[0]), 136'd0);
`endif

        do_reset();
        tick();
        check_eq("exp_q_empty", 136'(exp_q.size()), 136'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
